alu_issue_stage: RTL and testbench

- Sequential issue/writeback wrapper placed directly around the combinational ALU.
- Accepts one operation (opcode plus two operands) over a valid/ready handshake and latches it.
- Drives the latched values into the ALU, captures the ALU result into an output register, and presents it downstream over a second valid/ready handshake with status flags.
- Guards divide-by-zero so an undefined quotient never propagates downstream.

---
 rtl/alu_issue_stage.sv | 199 +++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// Purpose:
//   Sequential issue/writeback wrapper around a combinational ALU. One request
//   (opcode + two operands) is accepted over a valid/ready handshake. It is
//   latched and held on the ALU inputs. One cycle later the ALU result is
//   captured into an output register. The result is then presented downstream
//   over a second valid/ready handshake, together with zero and
//   divide-by-zero flags.
//
//   There is no overlap between requests: one operation is in flight at a time,
//   so the best case is one operation every three cycles.
//
// Ports:
//   clk, rst            - clock; synchronous active-high reset
//   in_valid/in_ready   - upstream handshake
//   in_oc, in_a, in_b   - opcode and operands
//                         (000 add, 001 sub, 010 mul, 011 div,
//                          100 not a, 101 xor, 110 or, 111 and)
//   alu_oc/alu_a/alu_b  - latched opcode/operands driven to the ALU
//   alu_f               - combinational ALU result
//   out_valid/out_ready - downstream handshake
//   out_f               - registered result
//   out_zero            - out_f == 0
//   out_dz              - divide-by-zero occurred (out_f forced to all ones)
//
// Optional build macro:
//   ALU_ISSUE_STATS_EN  - adds the saturating 16-bit counters op_count
//                         (completed operations) and dz_count
//                         (divide-by-zero results).
// -----------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_oc,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic [2:0]            alu_oc,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_f,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_f,
  output logic                  out_zero,
  output logic                  out_dz
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]           op_count,
  output logic [15:0]           dz_count
`endif
);

  localparam logic [2:0] OC_DIV = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                  accept;
  logic                  capture;
  logic                  release_res;

  logic [2:0]            oc_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] f_q;
  logic                  zero_q;
  logic                  dz_q;
  logic                  valid_q;

  logic                  dz_hit;
  logic [DATA_WIDTH-1:0] f_d;
  logic                  zero_d;

  // Saturating 16-bit increment used by the optional statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Control: state register plus next-state/handshake decode
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        capture = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          release_res = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // in_ready is gated by rst so that no request is taken while in reset.
  assign in_ready = (state_q == IDLE) && !rst;

  // ---------------------------------------------------------------------------
  // Issue stage: latch the request and hold it on the ALU inputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      oc_q <= 3'b000;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      oc_q <= in_oc;
      a_q  <= in_a;
      b_q  <= in_b;
    end
  end

  assign alu_oc = oc_q;
  assign alu_a  = a_q;
  assign alu_b  = b_q;

  // ---------------------------------------------------------------------------
  // Writeback stage: capture the ALU result and the status flags
  // ---------------------------------------------------------------------------
  // The select is fully known during a divide-by-zero, so an X on alu_f is
  // discarded by the mux and cannot reach out_f.
  assign dz_hit = (oc_q == OC_DIV) && (b_q == '0);
  assign f_d    = dz_hit ? {DATA_WIDTH{1'b1}} : alu_f;
  assign zero_d = (f_d == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q     <= '0;
      zero_q  <= 1'b0;
      dz_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (capture) begin
        f_q     <= f_d;
        zero_q  <= zero_d;
        dz_q    <= dz_hit;
        valid_q <= 1'b1;
      end else if (release_res) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_f     = f_q;
  assign out_zero  = zero_q;
  assign out_dz    = dz_q;
  assign out_valid = valid_q;

`ifdef ALU_ISSUE_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics: counted on the same edge as the result capture
  // ---------------------------------------------------------------------------
  logic [15:0] op_cnt_q;
  logic [15:0] dz_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_cnt_q <= 16'd0;
      dz_cnt_q <= 16'd0;
    end else if (capture) begin
      op_cnt_q <= sat_inc16(op_cnt_q);
      if (dz_hit) dz_cnt_q <= sat_inc16(dz_cnt_q);
    end
  end

  assign op_count = op_cnt_q;
  assign dz_count = dz_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Directed bench for alu_issue_stage. A small behavioural ALU closes the loop
// from alu_oc/alu_a/alu_b to alu_f. It drives X on alu_f for a divide by zero,
// so that leakage into out_f would be visible. All expected values below are
// worked out by hand.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_oc;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   alu_oc;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_f;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_f;
  logic         out_zero;
  logic         out_dz;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0]  op_count;
  logic [15:0]  dz_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  alu_issue_stage #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_oc     (in_oc),
    .in_a      (in_a),
    .in_b      (in_b),
    .alu_oc    (alu_oc),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_f     (alu_f),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_f     (out_f),
    .out_zero  (out_zero),
    .out_dz    (out_dz)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .op_count  (op_count),
    .dz_count  (dz_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU; an undefined quotient is modelled as X.
  always_comb begin
    alu_f = '0;
    case (alu_oc)
      3'b000: alu_f = alu_a + alu_b;
      3'b001: alu_f = alu_a - alu_b;
      3'b010: alu_f = alu_a * alu_b;
      3'b011: alu_f = (alu_b == '0) ? {W{1'bx}} : alu_a / alu_b;
      3'b100: alu_f = ~alu_a;
      3'b101: alu_f = alu_a ^ alu_b;
      3'b110: alu_f = alu_a | alu_b;
      default: alu_f = alu_a & alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction with out_ready high as soon as the result is valid.
  task automatic do_op(input string tag, input logic [2:0] oc, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_f,
                       input logic exp_z, input logic exp_dz);
    in_valid = 1'b1; in_oc = oc; in_a = a; in_b = b; out_ready = 1'b0;
    check({tag, ".rdy_idle"}, in_ready, 1);
    tick();                                   // accept edge N
    in_valid = 1'b0;
    check({tag, ".rdy_exec"}, in_ready, 0);
    check({tag, ".vld_exec"}, out_valid, 0);
    check({tag, ".alu_oc"}, alu_oc, oc);
    check({tag, ".alu_a"}, alu_a, a);
    check({tag, ".alu_b"}, alu_b, b);
    tick();                                   // capture edge N+1
    check({tag, ".vld_done"}, out_valid, 1);
    check({tag, ".f"}, out_f, exp_f);
    check({tag, ".zero"}, out_zero, exp_z);
    check({tag, ".dz"}, out_dz, exp_dz);
    check({tag, ".rdy_done"}, in_ready, 0);
    out_ready = 1'b1;
    tick();                                   // release edge N+2
    out_ready = 1'b0;
    check({tag, ".vld_rel"}, out_valid, 0);
    check({tag, ".rdy_rel"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_oc = 3'b000; in_a = '0; in_b = '0; out_ready = 1'b0;
    tick();
    tick();
    // Reset state
    check("rst.in_ready", in_ready, 0);
    check("rst.out_valid", out_valid, 0);
    check("rst.out_f", out_f, 0);
    check("rst.out_zero", out_zero, 0);
    check("rst.out_dz", out_dz, 0);
    check("rst.alu_a", alu_a, 0);
`ifdef ALU_ISSUE_STATS_EN
    check("rst.op_count", op_count, 0);
    check("rst.dz_count", dz_count, 0);
`endif
    rst = 1'b0;
    #1;
    check("post_rst.in_ready", in_ready, 1);

    // Main function and wrap/truncation
    do_op("add",     3'b000, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0);
    do_op("sub0",    3'b001, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0);
    do_op("mulwrap", 3'b010, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0);
    do_op("subwrap", 3'b001, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0);
    do_op("divz",    3'b011, 16'h0010, 16'h0000, 16'hFFFF, 1'b0, 1'b1);
    do_op("div",     3'b011, 16'h0010, 16'h0004, 16'h0004, 1'b0, 1'b0);
    do_op("not",     3'b100, 16'h00F0, 16'h1234, 16'hFF0F, 1'b0, 1'b0);
    do_op("or",      3'b110, 16'h0A00, 16'h00A0, 16'h0AA0, 1'b0, 1'b0);
    do_op("and",     3'b111, 16'hF0F0, 16'h0F0F, 16'h0000, 1'b1, 1'b0);

    // Backpressure: xor held in DONE for 5 cycles while new requests are offered
    in_valid = 1'b1; in_oc = 3'b101; in_a = 16'h00FF; in_b = 16'h0F0F; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    check("bp.vld", out_valid, 1);
    check("bp.f", out_f, 16'h0FF0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_oc = 3'b000; in_a = 16'h1111 + 16'(i); in_b = 16'h2222;
      tick();
      check("bp.hold_vld", out_valid, 1);
      check("bp.hold_f", out_f, 16'h0FF0);
      check("bp.hold_flags", {out_zero, out_dz}, 2'b00);
      check("bp.hold_rdy", in_ready, 0);
      check("bp.hold_alu_a", alu_a, 16'h00FF);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp.rel_vld", out_valid, 0);
    check("bp.rel_rdy", in_ready, 1);
    check("bp.alu_a_held", alu_a, 16'h00FF);

    // Reset during EXEC discards the operation
    in_valid = 1'b1; in_oc = 3'b000; in_a = 16'h0007; in_b = 16'h0008;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    check("rexec.rdy_in_rst", in_ready, 0);
    tick();
    check("rexec.vld", out_valid, 0);
    check("rexec.f", out_f, 0);
    check("rexec.alu_a", alu_a, 0);
    rst = 1'b0;
    #1;
    check("rexec.rdy_after", in_ready, 1);
    tick();
    check("rexec.vld_after", out_valid, 0);
    do_op("add11", 3'b000, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);
    do_op("divz2", 3'b011, 16'h0020, 16'h0000, 16'hFFFF, 1'b0, 1'b1);
    do_op("xor",   3'b101, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b0);

`ifdef ALU_ISSUE_STATS_EN
    check("stats.op_count", op_count, 3);
    check("stats.dz_count", dz_count, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("stats.op_rst", op_count, 0);
    check("stats.dz_rst", dz_count, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
